// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-test game: FSM states,
// segment patterns, LFSR definition and the BCD magnitude compare.
package reaction_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_GO,
    S_DONE,
    S_FALSE
  } state_t;

  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [6:0]  SEG_DASH  = 7'h3F;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Numeric compare of up to 8 BCD digits, most significant digit first.
  function automatic logic bcd_less(input logic [31:0] a, input logic [31:0] b);
    logic decided;
    logic lt;
    int unsigned idx;
    decided = 1'b0;
    lt      = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = 7 - k;
      if (!decided && (a[4*idx +: 4] != b[4*idx +: 4])) begin
        lt      = (a[4*idx +: 4] < b[4*idx +: 4]);
        decided = 1'b1;
      end
    end
    return lt;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// One BCD digit to active-low 7-segment pattern (gfedcba); non-decimal
// codes show blank.
module bcd_to_7seg
  import reaction_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/reaction_tester.sv
// Single-button reaction-test game: random pre-stimulus wait, false-start
// detection, BCD millisecond timing, best-time tracking and 7-seg drive.
module reaction_tester
  import reaction_pkg::*;
#(
  parameter int TICK_DIV    = 10000,
  parameter int DIGITS      = 4,
  parameter int MIN_WAIT_MS = 1000,
  parameter int RAND_BITS   = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn,
  input  logic                  clear_best,
  output logic                  led,
  output logic [4*DIGITS-1:0]   result,
  output logic [4*DIGITS-1:0]   best,
  output logic                  false_start,
  output logic                  timeout,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int WW = $clog2(MIN_WAIT_MS + 2**RAND_BITS) + 1;
  localparam int BW = 4 * DIGITS;
  localparam logic [BW-1:0] ALL9 = {DIGITS{4'h9}};

  state_t            state, nxt;
  logic [PW-1:0]     presc;
  logic              tick;
  logic [WW-1:0]     wait_cnt;
  logic [BW-1:0]     cnt, cnt_inc;
  logic [15:0]       lfsr;
  logic              press_ok, sat;
  logic [BW-1:0]     seg_src;
  logic [7*DIGITS-1:0] dig_seg;

  assign tick = (presc == PW'(TICK_DIV - 1));

  always_comb begin
    nxt      = state;
    press_ok = 1'b0;
    sat      = 1'b0;
    case (state)
      S_IDLE:  if (btn) nxt = S_WAIT;
      S_WAIT: begin
        // A press outranks a same-cycle expiring tick.
        if (btn) nxt = S_FALSE;
        else if (tick && (wait_cnt <= WW'(1))) nxt = S_GO;
      end
      S_GO: begin
        if (btn) begin
          nxt      = S_DONE;
          press_ok = 1'b1;
        end else if (tick && (cnt == ALL9)) begin
          nxt = S_DONE;
          sat = 1'b1;
        end
      end
      S_DONE, S_FALSE: if (btn) nxt = S_WAIT;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    logic carry;
    logic [3:0] nib;
    cnt_inc = '0;
    carry   = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      nib = cnt[4*i +: 4];
      if (carry) begin
        if (nib == 4'd9) nib = 4'd0;
        else begin
          nib   = nib + 4'd1;
          carry = 1'b0;
        end
      end
      cnt_inc[4*i +: 4] = nib;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      presc       <= '0;
      lfsr        <= LFSR_SEED;
      wait_cnt    <= '0;
      cnt         <= '0;
      result      <= '0;
      best        <= ALL9;
      led         <= 1'b0;
      false_start <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state <= nxt;
      lfsr  <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};

      if ((nxt != state) || tick) presc <= '0;
      else                        presc <= presc + PW'(1);

      if ((nxt == S_WAIT) && (state != S_WAIT))
        wait_cnt <= WW'(MIN_WAIT_MS) + WW'(lfsr[RAND_BITS-1:0]);
      else if ((state == S_WAIT) && tick)
        wait_cnt <= wait_cnt - WW'(1);

      if ((nxt == S_GO) && (state != S_GO)) cnt <= '0;
      else if ((state == S_GO) && tick && !btn) cnt <= cnt_inc;

      if (press_ok) result <= cnt;
      else if (sat) result <= ALL9;

      if (clear_best) best <= ALL9;
      else if (press_ok && bcd_less(32'(cnt), 32'(best))) best <= cnt;

      led         <= (nxt == S_GO);
      false_start <= (nxt == S_FALSE);
      timeout     <= (nxt == S_DONE) && (sat || ((state == S_DONE) && timeout));
    end
  end

  assign seg_src = (state == S_GO) ? cnt : result;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    bcd_to_7seg u_dec (
      .bcd (seg_src[4*g +: 4]),
      .seg (dig_seg[7*g +: 7])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg <= {DIGITS{SEG_BLANK}};
    end else begin
      case (state)
        S_GO, S_DONE: seg <= dig_seg;
        S_FALSE:      seg <= {DIGITS{SEG_DASH}};
        default:      seg <= {DIGITS{SEG_BLANK}};
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_tester.sv
// Scoreboarded bench for reaction_tester: stimulus queues expected trial
// outcomes and GO latencies; a negedge monitor pops and compares them.
module tb_reaction_tester;

  localparam int TD = 4;
  localparam int DG = 2;
  localparam int MW = 2;
  localparam int RB = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn = 1'b0;
  logic          clear_best = 1'b0;
  logic          led;
  logic [7:0]    result;
  logic [7:0]    best;
  logic          false_start;
  logic          timeout;
  logic [13:0]   seg;

  always #5 clk = ~clk;

  reaction_tester #(
    .TICK_DIV    (TD),
    .DIGITS      (DG),
    .MIN_WAIT_MS (MW),
    .RAND_BITS   (RB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn         (btn),
    .clear_best  (clear_best),
    .led         (led),
    .result      (result),
    .best        (best),
    .false_start (false_start),
    .timeout     (timeout),
    .seg         (seg)
  );

  typedef struct {
    logic [7:0]  result;
    logic [7:0]  best;
    logic        tmo;
    logic        fs;
    logic [13:0] seg;
  } exp_t;

  exp_t        exp_q[$];
  int          led_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic        last_rst = 1'b0;
  logic [15:0] m_lfsr = 16'hACE1;
  int          m_best = 99;
  int          m_result = 0;

  // Reference LFSR: x^16+x^14+x^13+x^11, shifting left, new bit at LSB.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    last_rst <= rst_n;
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic logic [6:0] seg_dig(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [13:0] seg_num(input logic [7:0] v);
    return {seg_dig(v[7:4]), seg_dig(v[3:0])};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s bound expired (cycle %0d)", name, cyc);
  endtask

  // Monitor
  logic        prev_led = 1'b0;
  logic        prev_fs = 1'b0;
  logic        seg_pend = 1'b0;
  logic [13:0] seg_exp = '0;

  always @(negedge clk) begin
    exp_t e;
    int   t;
    if (!last_rst) begin
      seg_pend = 1'b0;
    end else begin
      if (seg_pend) begin
        chk("outcome_seg", 32'(seg), 32'(seg_exp));
        seg_pend = 1'b0;
      end
      if (led && !prev_led) begin
        if (led_q.size() == 0) fail_now("led_unexpected_rise");
        else begin
          t = led_q.pop_front();
          chk("go_latency_cycle", cyc, t);
        end
      end
      if ((!led && prev_led) || (false_start && !prev_fs)) begin
        if (exp_q.size() == 0) fail_now("outcome_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("result", 32'(result), 32'(e.result));
          chk("best", 32'(best), 32'(e.best));
          chk("timeout", 32'(timeout), 32'(e.tmo));
          chk("false_start", 32'(false_start), 32'(e.fs));
          seg_exp  = e.seg;
          seg_pend = 1'b1;
        end
      end
    end
    prev_led = led;
    prev_fs  = false_start;
  end

  task automatic check_reset();
    chk("rst_led", 32'(led), 0);
    chk("rst_false_start", 32'(false_start), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_result", 32'(result), 32'h00);
    chk("rst_best", 32'(best), 32'h99);
    chk("rst_seg", 32'(seg), 32'h3FFF);
  endtask

  // Called at a negedge; the press is sampled at the next posedge.
  task automatic start_trial(input bit expect_go, output int w);
    w = MW + int'(m_lfsr[RB-1:0]);
    if (expect_go) led_q.push_back(cyc + 1 + TD * w);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
  endtask

  task automatic wait_go(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (led) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("wait_for_led");
  endtask

  // Press sampled at GO-entry edge + TD*n + j; j==0 lands on the tick edge.
  task automatic press_go(input int n, input int j, input bit clr);
    int   cnt;
    exp_t e;
    cnt = (j == 0) ? n - 1 : n;
    repeat (TD * n + j - 1) @(negedge clk);
    m_result = cnt;
    if (clr) m_best = 99;
    else if (cnt < m_best) m_best = cnt;
    e.result = to_bcd(cnt);
    e.best   = to_bcd(m_best);
    e.tmo    = 1'b0;
    e.fs     = 1'b0;
    e.seg    = seg_num(to_bcd(cnt));
    exp_q.push_back(e);
    btn = 1'b1;
    clear_best = clr;
    @(negedge clk);
    btn = 1'b0;
    clear_best = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic go_trial(input int n, input int j, input bit clr);
    int w;
    bit ok;
    start_trial(1'b1, w);
    wait_go(ok);
    if (ok) press_go(n, j, clr);
  endtask

  task automatic false_trial();
    int   w;
    int   d;
    exp_t e;
    start_trial(1'b0, w);
    d = $urandom_range(1, TD * w);
    repeat (d - 1) @(negedge clk);
    e.result = to_bcd(m_result);
    e.best   = to_bcd(m_best);
    e.tmo    = 1'b0;
    e.fs     = 1'b1;
    e.seg    = {7'h3F, 7'h3F};
    exp_q.push_back(e);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    repeat (TD * w + 4) @(negedge clk);
  endtask

  task automatic timeout_trial();
    int   w;
    int   e_cyc;
    bit   ok;
    bit   fell;
    exp_t e;
    start_trial(1'b1, w);
    wait_go(ok);
    if (ok) begin
      e_cyc    = cyc;
      m_result = 99;
      e.result = 8'h99;
      e.best   = to_bcd(m_best);
      e.tmo    = 1'b1;
      e.fs     = 1'b0;
      e.seg    = seg_num(8'h99);
      exp_q.push_back(e);
      fell = 1'b0;
      for (int i = 0; i < 450; i++) begin
        @(negedge clk);
        if (!led) begin
          fell = 1'b1;
          break;
        end
      end
      if (!fell) fail_now("wait_for_timeout");
      else chk("timeout_latency", cyc, e_cyc + 100 * TD);
      repeat (3) @(negedge clk);
      start_trial(1'b0, w);
      chk("timeout_cleared_on_exit", 32'(timeout), 0);
      btn = 1'b1;
      e.result = to_bcd(m_result);
      e.best   = to_bcd(m_best);
      e.tmo    = 1'b0;
      e.fs     = 1'b1;
      e.seg    = {7'h3F, 7'h3F};
      exp_q.push_back(e);
      @(negedge clk);
      btn = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  w;
    bit  ok;
    rst_n = 1'b0;
    btn   = 1'b1;
    repeat (3) @(negedge clk);
    check_reset();
    btn   = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    go_trial(7, 1, 1'b0);
    false_trial();
    timeout_trial();

    clear_best = 1'b1;
    @(negedge clk);
    clear_best = 1'b0;
    m_best = 99;
    chk("clear_best_idle_state", 32'(best), 32'h99);

    go_trial(12, 2, 1'b0);
    go_trial(5, 2, 1'b0);
    go_trial(9, 2, 1'b0);
    go_trial($urandom_range(1, 20), 1, 1'b1);
    go_trial(6, 0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 3) == 0) false_trial();
      else go_trial($urandom_range(1, 25), $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
    end

    start_trial(1'b1, w);
    wait_go(ok);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset();
    rst_n    = 1'b1;
    m_best   = 99;
    m_result = 0;
    @(negedge clk);

    go_trial(3, 3, 1'b0);
    repeat (6) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("go_queue_drained", led_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reaction_tester.md
# reaction_tester

Parametrised successor to the single-shot reaction timer: a complete reaction-test game on one button. A pseudo-random wait precedes the stimulus LED. The block detects false starts, counts reaction time in BCD milliseconds, and tracks the best time. It drives a DIGITS-wide active-low 7-segment bank directly and sits between the debounced-button front end and the display pins.

## Interface
- TICK_DIV, 10000: clk cycles per 1 ms tick; must be ≥2.
- DIGITS, 4: BCD display/result digits, 1..8.
- MIN_WAIT_MS, 1000: fixed part of the pre-stimulus wait.
- RAND_BITS, 10: width of the random wait addend, 0..2^RAND_BITS-1 ms; 1..16.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- btn  in  1  one-cycle press pulse, already debounced and synchronised.
- clear_best  in  1  one-cycle pulse; sets best to all-9s.
- led  out  1  stimulus LED; high only in GO.
- result  out  4*DIGITS  BCD of last valid reaction.
- best  out  4*DIGITS  BCD minimum of valid reactions since reset/clear.
- false_start  out  1  high while in FALSE.
- timeout  out  1  high while in DONE if the count saturated.
- seg  out  7*DIGITS  active-low segments, digit 0 at [6:0], bit order gfedcba.

## Operation
- States: IDLE, WAIT, GO, DONE, FALSE.
- IDLE: entered only from reset. btn → WAIT.
- Entering WAIT: load wait_cnt = MIN_WAIT_MS + lfsr[RAND_BITS-1:0]. Clear the prescaler.
- WAIT: decrement wait_cnt on each tick. Tick with wait_cnt==1 → GO, clear the BCD counter.
  - btn → FALSE; the tick in the same cycle is ignored.
  - MIN_WAIT_MS=0 with addend 0 → GO on the first tick.
- GO: led=1. BCD counter increments on each tick, digit by digit with ripple carry 9→0.
  - btn → DONE. result ← counter; the same-cycle tick is discarded.
  - If result < best (numeric BCD compare), best ← result.
  - Tick with counter all-9s → DONE, result ← all-9s, timeout=1, best not updated.
- DONE, FALSE: btn → WAIT (new trial). false_start and timeout clear on leaving.
- clear_best is honoured in any state. If it coincides with a best update, clear wins.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Steps every cycle. Reset seed 16'hACE1; never all-zero.
- Prescaler: counts 0..TICK_DIV-1. Tick is the cycle it equals TICK_DIV-1. It resets to 0 on every state change.
- Display, registered:
  - IDLE and WAIT: all digits blank (7'h7F).
  - GO: live counter.
  - DONE: result.
  - FALSE: dash on every digit (7'h3F).
  - Non-decimal nibbles decode to blank.

## Timing
- Reset (rst_n low at a clk edge) gives:
  - state IDLE, led 0, false_start 0, timeout 0.
  - result 0, best all-9s, seg all 7'h7F.
  - prescaler 0, LFSR seed.
- Reset overrides every input in the same cycle. Mid-trial reset discards the trial.
- led, false_start and timeout are registered state decodes, valid in the cycle after the transition edge.
- seg lags the value it shows by one cycle.
- First GO tick arrives TICK_DIV cycles after GO entry. A press exactly N ticks after GO reports N.
- result and best update on the btn edge and are visible the next cycle.

## Structure
- Package reaction_pkg:
  - state enum.
  - SEG_BLANK=7'h7F, SEG_DASH=7'h3F.
  - LFSR_SEED, LFSR_TAPS.
  - helper function for the BCD compare.
- Sub-module bcd_to_7seg: 4-bit in, 7-bit active-low out, combinational. Instantiated DIGITS times via generate.
- wait_cnt width: $clog2(MIN_WAIT_MS + 2^RAND_BITS) + 1.

## Test plan
Parameters for all cases: TICK_DIV=4, DIGITS=2, MIN_WAIT_MS=2, RAND_BITS=2.
- Reset with btn held → IDLE, led 0, seg 14'h3FFF, best 8'h99, result 8'h00.
- btn → WAIT; wait for led → led rises after (2+lfsr[1:0])*4 cycles (checked against a model LFSR); press after 7 ticks → result 8'h07, best 8'h07, seg shows "07" one cycle later.
- Press during WAIT → false_start 1, seg all 7'h3F, led never rises; next btn → WAIT with new random wait.
- Let GO run 99 ticks plus one → timeout 1, result 8'h99, best unchanged.
- Trials of 12 then 5 then 9 ticks → best 8'h12 → 8'h05 → 8'h05. clear_best coincident with the next update → best 8'h99.
- Press on the exact tick cycle in GO → count excludes that tick. Reset mid-GO → all reset values next cycle.
